// File: rtl/btn_debounce.sv
// btn_debounce: debounced push-button input block.
// Each raw pin is polarity-normalised (1 = pressed), passed through a
// two-flop synchroniser and filtered by a per-button FSM. The block reports
// a stable level, one-cycle press/release/long-press pulses, a held-past-long
// level and an 8-bit wrapping press counter per button.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   btn_in       raw asynchronous button pins, one bit per button
//   btn_state    debounced level, 1 = pressed
//   btn_press    one-cycle pulse when a press is accepted
//   btn_release  one-cycle pulse when a release is accepted
//   btn_long     one-cycle pulse when a press has lasted LONG_CYC cycles
//   btn_hold     1 from btn_long until the release is accepted
//   btn_cnt      accepted-press count, button i in bits [8i+7:8i]
module btn_debounce #(
  parameter int unsigned CLOCK_XTAL     = 27000000,
  parameter int unsigned BTN_NUM        = 2,
  parameter int unsigned DEBOUNCE_CYC   = CLOCK_XTAL / 100,
  parameter int unsigned LONG_CYC       = CLOCK_XTAL,
  parameter bit          BTN_ACTIVE_LOW = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BTN_NUM-1:0]   btn_in,
  output logic [BTN_NUM-1:0]   btn_state,
  output logic [BTN_NUM-1:0]   btn_press,
  output logic [BTN_NUM-1:0]   btn_release,
  output logic [BTN_NUM-1:0]   btn_long,
  output logic [BTN_NUM-1:0]   btn_hold,
  output logic [8*BTN_NUM-1:0] btn_cnt
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned HW = $clog2(LONG_CYC + 1);

  localparam logic [DW-1:0]      DBC_ONE  = DW'(1);
  localparam logic [DW-1:0]      DBC_LAST = DW'(DEBOUNCE_CYC - 1);
  localparam logic [HW-1:0]      HC_LAST  = HW'(LONG_CYC - 1);
  localparam logic [HW-1:0]      HC_MAX   = HW'(LONG_CYC);
  localparam logic [BTN_NUM-1:0] POL      = BTN_ACTIVE_LOW ? '1 : '0;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  logic [BTN_NUM-1:0] s1;
  logic [BTN_NUM-1:0] s2;

  state_t        state_q [BTN_NUM];
  state_t        state_d [BTN_NUM];
  logic [DW-1:0] dbc_q   [BTN_NUM];
  logic [DW-1:0] dbc_d   [BTN_NUM];
  logic [HW-1:0] hc_q    [BTN_NUM];
  logic [HW-1:0] hc_d    [BTN_NUM];

  logic [BTN_NUM-1:0]   press_commit;
  logic [BTN_NUM-1:0]   release_commit;
  logic [BTN_NUM-1:0]   state_nx;
  logic [BTN_NUM-1:0]   press_nx;
  logic [BTN_NUM-1:0]   release_nx;
  logic [BTN_NUM-1:0]   long_nx;
  logic [BTN_NUM-1:0]   hold_nx;
  logic [8*BTN_NUM-1:0] cnt_nx;

  always_comb begin
    press_commit   = '0;
    release_commit = '0;
    state_nx       = btn_state;
    press_nx       = '0;
    release_nx     = '0;
    long_nx        = '0;
    hold_nx        = btn_hold;
    cnt_nx         = btn_cnt;
    for (int unsigned i = 0; i < BTN_NUM; i++) begin
      state_d[i] = state_q[i];
      dbc_d[i]   = '0;
      hc_d[i]    = hc_q[i];

      // The sample that moves the FSM into a WAIT state is the first stable
      // sample, so dbc enters at 1; a commit therefore needs DEBOUNCE_CYC
      // consecutive samples of the new level, and DEBOUNCE_CYC==1 commits
      // straight from IDLE/PRESSED.
      case (state_q[i])
        IDLE: begin
          if (s2[i]) begin
            if (DEBOUNCE_CYC == 1) begin
              press_commit[i] = 1'b1;
            end else begin
              state_d[i] = PRESS_WAIT;
              dbc_d[i]   = DBC_ONE;
            end
          end
        end
        PRESS_WAIT: begin
          if (!s2[i]) begin
            state_d[i] = IDLE;
          end else if (dbc_q[i] == DBC_LAST) begin
            press_commit[i] = 1'b1;
          end else begin
            dbc_d[i] = dbc_q[i] + DBC_ONE;
          end
        end
        PRESSED: begin
          if (!s2[i]) begin
            if (DEBOUNCE_CYC == 1) begin
              release_commit[i] = 1'b1;
            end else begin
              state_d[i] = RELEASE_WAIT;
              dbc_d[i]   = DBC_ONE;
            end
          end
        end
        RELEASE_WAIT: begin
          if (s2[i]) begin
            state_d[i] = PRESSED;
          end else if (dbc_q[i] == DBC_LAST) begin
            release_commit[i] = 1'b1;
          end else begin
            dbc_d[i] = dbc_q[i] + DBC_ONE;
          end
        end
        default: state_d[i] = IDLE;
      endcase

      // Hold timer keeps running through release bounce; a release commit on
      // the threshold edge suppresses the long-press event.
      if (state_q[i] == PRESSED || state_q[i] == RELEASE_WAIT) begin
        if (hc_q[i] != HC_MAX) begin
          hc_d[i] = hc_q[i] + HW'(1);
        end
        if (hc_q[i] == HC_LAST && !release_commit[i]) begin
          long_nx[i] = 1'b1;
          hold_nx[i] = 1'b1;
        end
      end

      if (press_commit[i]) begin
        state_d[i]        = PRESSED;
        hc_d[i]           = '0;
        state_nx[i]       = 1'b1;
        press_nx[i]       = 1'b1;
        cnt_nx[8*i +: 8]  = btn_cnt[8*i +: 8] + 8'd1;
      end

      if (release_commit[i]) begin
        state_d[i]    = IDLE;
        hc_d[i]       = '0;
        state_nx[i]   = 1'b0;
        release_nx[i] = 1'b1;
        hold_nx[i]    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1          <= '0;
      s2          <= '0;
      btn_state   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      btn_long    <= '0;
      btn_hold    <= '0;
      btn_cnt     <= '0;
      for (int unsigned i = 0; i < BTN_NUM; i++) begin
        state_q[i] <= IDLE;
        dbc_q[i]   <= '0;
        hc_q[i]    <= '0;
      end
    end else begin
      s1          <= btn_in ^ POL;
      s2          <= s1;
      btn_state   <= state_nx;
      btn_press   <= press_nx;
      btn_release <= release_nx;
      btn_long    <= long_nx;
      btn_hold    <= hold_nx;
      btn_cnt     <= cnt_nx;
      state_q     <= state_d;
      dbc_q       <= dbc_d;
      hc_q        <= hc_d;
    end
  end

endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: scoreboard bench for btn_debounce.
// Two instances run side by side, one active-high and one active-low, fed
// with the same normalised stimulus. The stimulus process advances a
// reference model (run-length acceptance, press-edge timestamps) and pushes
// the expected outputs for each edge; the monitor pops and compares them.
module tb_btn_debounce;

  localparam int unsigned D    = 4;
  localparam int unsigned LG   = 20;
  localparam int unsigned MAXE = 16000;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pin_h;
  logic [1:0]  pin_l;

  logic [1:0]  st_h, pr_h, rl_h, lg_h, hd_h;
  logic [15:0] cnt_h;
  logic [1:0]  st_l, pr_l, rl_l, lg_l, hd_l;
  logic [15:0] cnt_l;

  btn_debounce #(
    .CLOCK_XTAL    (27000000),
    .BTN_NUM       (2),
    .DEBOUNCE_CYC  (D),
    .LONG_CYC      (LG),
    .BTN_ACTIVE_LOW(1'b0)
  ) dut_h (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (pin_h),
    .btn_state  (st_h),
    .btn_press  (pr_h),
    .btn_release(rl_h),
    .btn_long   (lg_h),
    .btn_hold   (hd_h),
    .btn_cnt    (cnt_h)
  );

  btn_debounce #(
    .CLOCK_XTAL    (27000000),
    .BTN_NUM       (2),
    .DEBOUNCE_CYC  (D),
    .LONG_CYC      (LG),
    .BTN_ACTIVE_LOW(1'b1)
  ) dut_l (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (pin_l),
    .btn_state  (st_l),
    .btn_press  (pr_l),
    .btn_release(rl_l),
    .btn_long   (lg_l),
    .btn_hold   (hd_l),
    .btn_cnt    (cnt_l)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned edge_no;
    logic [1:0]  st;
    logic [1:0]  pr;
    logic [1:0]  rl;
    logic [1:0]  lg;
    logic [1:0]  hd;
    logic [15:0] cnt;
  } exp_t;

  exp_t        expq[$];
  int unsigned total = 0;
  int unsigned bad   = 0;
  bit          stim_done = 1'b0;
  bit          started   = 1'b0;

  // Reference model: a level is accepted once the synchronised pin (pin
  // delayed two edges, forced to 0 for two edges after reset) has shown the
  // opposite level for D consecutive edges; long fires LG edges after the
  // press commit unless the release commits on that very edge.
  logic [1:0]  hist [0:MAXE];
  int unsigned t_now    = 0;
  int unsigned last_rst = 0;
  bit          m_lvl  [2];
  int unsigned m_run  [2];
  int unsigned m_pe   [2];
  logic [7:0]  m_cnt  [2];
  bit          m_hold [2];

  task automatic model_step(input logic r, input logic [1:0] p, output exp_t e);
    logic [1:0] seen;
    t_now++;
    hist[t_now] = p;
    e.edge_no = t_now;
    e.pr = 2'b00;
    e.rl = 2'b00;
    e.lg = 2'b00;
    if (r) begin
      last_rst = t_now;
      for (int b = 0; b < 2; b++) begin
        m_lvl[b]  = 1'b0;
        m_run[b]  = 0;
        m_pe[b]   = 0;
        m_cnt[b]  = 8'd0;
        m_hold[b] = 1'b0;
      end
    end else begin
      seen = (t_now >= last_rst + 3) ? hist[t_now-2] : 2'b00;
      for (int b = 0; b < 2; b++) begin
        if (seen[b] != m_lvl[b]) m_run[b]++;
        else m_run[b] = 0;
        if (m_run[b] == D) begin
          m_run[b] = 0;
          if (!m_lvl[b]) begin
            m_lvl[b] = 1'b1;
            e.pr[b]  = 1'b1;
            m_cnt[b] = m_cnt[b] + 8'd1;
            m_pe[b]  = t_now;
          end else begin
            m_lvl[b]  = 1'b0;
            e.rl[b]   = 1'b1;
            m_hold[b] = 1'b0;
          end
        end else if (m_lvl[b] && (t_now - m_pe[b] == LG)) begin
          e.lg[b]   = 1'b1;
          m_hold[b] = 1'b1;
        end
      end
    end
    e.st  = {m_lvl[1], m_lvl[0]};
    e.hd  = {m_hold[1], m_hold[0]};
    e.cnt = {m_cnt[1], m_cnt[0]};
  endtask

  task automatic drive(input logic [1:0] norm, input logic r);
    exp_t e;
    if (started) @(negedge clk);
    started = 1'b1;
    pin_h = norm;
    pin_l = ~norm;
    rst   = r;
    model_step(r, norm, e);
    expq.push_back(e);
  endtask

  task automatic hold_for(input int unsigned n, input logic [1:0] norm, input logic r);
    for (int unsigned k = 0; k < n; k++) drive(norm, r);
  endtask

  task automatic chk(input string nm, input int unsigned e,
                     input logic [15:0] act, input logic [15:0] want);
    total++;
    if (act !== want) begin
      bad++;
      if (bad <= 40)
        $display("FAIL %s edge=%0d got=%h want=%h", nm, e, act, want);
    end
  endtask

  // Stimulus
  initial begin
    logic [1:0]  lvl;
    int unsigned rem [2];
    pin_h = 2'b00;
    pin_l = 2'b11;
    rst   = 1'b1;
    hold_for(3, 2'b00, 1'b1);
    hold_for(2, 2'b00, 1'b0);

    // clean press with long press, then release
    hold_for(30, 2'b01, 1'b0);
    hold_for(15, 2'b00, 1'b0);

    // bounce rejection from a fresh reset, then a minimum-length press
    hold_for(1, 2'b00, 1'b1);
    drive(2'b01, 1'b0);
    drive(2'b00, 1'b0);
    drive(2'b01, 1'b0);
    drive(2'b01, 1'b0);
    drive(2'b00, 1'b0);
    hold_for(10, 2'b00, 1'b0);
    hold_for(4,  2'b01, 1'b0);
    hold_for(12, 2'b00, 1'b0);
    hold_for(3,  2'b01, 1'b0);
    hold_for(12, 2'b00, 1'b0);

    // release bounce mid-hold
    hold_for(10, 2'b01, 1'b0);
    hold_for(2,  2'b00, 1'b0);
    hold_for(20, 2'b01, 1'b0);
    hold_for(12, 2'b00, 1'b0);

    // release commit on the long threshold edge, then one edge later
    hold_for(20, 2'b01, 1'b0);
    hold_for(12, 2'b00, 1'b0);
    hold_for(21, 2'b01, 1'b0);
    hold_for(12, 2'b00, 1'b0);

    // counter wrap on button 1, button 0 idle
    for (int n = 0; n < 256; n++) begin
      hold_for(6, 2'b10, 1'b0);
      hold_for(6, 2'b00, 1'b0);
    end
    hold_for(6, 2'b10, 1'b0);
    hold_for(6, 2'b00, 1'b0);

    // simultaneous press, reset while held, fresh press afterwards
    hold_for(10, 2'b11, 1'b0);
    hold_for(1,  2'b11, 1'b1);
    hold_for(12, 2'b11, 1'b0);
    hold_for(12, 2'b00, 1'b0);

    // randomized run lengths with occasional reset
    lvl = 2'b00;
    rem[0] = 1;
    rem[1] = 1;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 2; b++) begin
        rem[b]--;
        if (rem[b] == 0) begin
          lvl[b] = ~lvl[b];
          rem[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(4, 30)
                                               : $urandom_range(1, 5);
        end
      end
      drive(lvl, ($urandom_range(0, 399) == 0));
    end
    hold_for(40, 2'b00, 1'b0);

    @(posedge clk);
    stim_done = 1'b1;
  end

  // Monitor
  initial begin
    int unsigned e;
    exp_t x;
    e = 0;
    while (!(stim_done && expq.size() == 0) && e < MAXE) begin
      @(posedge clk);
      #1;
      e++;
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL queue edge=%0d got=empty want=entry", e);
      end else begin
        x = expq.pop_front();
        chk("state_h",   e, 16'(st_h), 16'(x.st));
        chk("press_h",   e, 16'(pr_h), 16'(x.pr));
        chk("release_h", e, 16'(rl_h), 16'(x.rl));
        chk("long_h",    e, 16'(lg_h), 16'(x.lg));
        chk("hold_h",    e, 16'(hd_h), 16'(x.hd));
        chk("cnt_h",     e, cnt_h,     x.cnt);
        chk("state_l",   e, 16'(st_l), 16'(x.st));
        chk("press_l",   e, 16'(pr_l), 16'(x.pr));
        chk("release_l", e, 16'(rl_l), 16'(x.rl));
        chk("long_l",    e, 16'(lg_l), 16'(x.lg));
        chk("hold_l",    e, 16'(hd_l), 16'(x.hd));
        chk("cnt_l",     e, cnt_l,     x.cnt);
      end
    end
    if (e >= MAXE) begin
      total++;
      bad++;
      $display("FAIL timeout edge=%0d got=running want=done", e);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
